// File: rtl/aibcr3_txdig_ctl.sv
// aibcr3_txdig_ctl
// Transmit-side digital control for one AIB IO. Decodes the 3-bit itxen mode,
// sequences driver wake (ARM preamble) and drain, and formats DDR / SDR /
// clock-pattern data into a fixed-depth pipeline that feeds the pad serializer.
// odat0 carries the rising-half bit and odat1 the falling-half bit.

module aibcr3_txdig_ctl #(
   parameter int unsigned WAKE_CYC  = 4,
   parameter int unsigned DRAIN_CYC = 2,
   parameter int unsigned PIPE_STG  = 2,
   parameter int unsigned CNT_W     = 4
) (
   input  logic       iclkin_dist,
   input  logic       irst,
   input  logic       ipadrstb,
   input  logic [2:0] itxen,
   input  logic       idat0,
   input  logic       idat1,
   input  logic       iasync_dat,
   output logic       odat0,
   output logic       odat1,
   output logic       oasync_dat,
   output logic       otx_oe,
   output logic       owkpd_en,
   output logic       otx_ready
);

   // Mode encodings shared with the RX digital.
   localparam logic [2:0] MODE_ASYNC = 3'b000;
   localparam logic [2:0] MODE_DDR   = 3'b001;
   localparam logic [2:0] MODE_DIS   = 3'b010;
   localparam logic [2:0] MODE_CLK   = 3'b011;
   localparam logic [2:0] MODE_SDR   = 3'b100;

   // Counter reload values: the preamble and the drain both count down to zero.
   // The drain covers the words still in the pipeline plus the driven-zero tail.
   localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYC - 1);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(PIPE_STG + DRAIN_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_ARM   = 2'd1,
      ST_ON    = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t                     state_r;
   state_t                     state_nxt_s;
   logic [CNT_W-1:0]           cnt_r;
   logic [CNT_W-1:0]           cnt_nxt_s;
   logic [2:0]                 act_mode_r;
   logic [2:0]                 act_mode_nxt_s;
   logic [2:0]                 eff_mode_s;
   logic [1:0]                 pipe_in_s;
   logic [PIPE_STG-1:0][1:0]   pipe_r;
   logic                       oe_r;

   // Effective mode: pad reset forces disable, reserved encodings act as disable.
   always_comb begin
      eff_mode_s = MODE_DIS;
      if (ipadrstb) begin
         case (itxen)
            MODE_ASYNC, MODE_DDR, MODE_CLK, MODE_SDR: eff_mode_s = itxen;
            default:                                  eff_mode_s = MODE_DIS;
         endcase
      end else begin
         eff_mode_s = MODE_DIS;
      end
   end

   // Next-state, counter and latched-mode logic for the wake/on/drain sequencer.
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      act_mode_nxt_s = act_mode_r;
      case (state_r)
         ST_OFF: begin
            if (eff_mode_s != MODE_DIS) begin
               state_nxt_s    = ST_ARM;
               cnt_nxt_s      = WAKE_LOAD;
               act_mode_nxt_s = eff_mode_s;
            end else begin
               state_nxt_s = ST_OFF;
            end
         end
         ST_ARM: begin
            if (eff_mode_s == MODE_DIS) begin
               // Nothing has been sent yet, so release without a drain.
               state_nxt_s = ST_OFF;
               cnt_nxt_s   = CNT_ZERO;
            end else if (eff_mode_s != act_mode_r) begin
               // Mode changed mid-preamble: restart the full preamble.
               state_nxt_s    = ST_ARM;
               cnt_nxt_s      = WAKE_LOAD;
               act_mode_nxt_s = eff_mode_s;
            end else if (cnt_r == CNT_ZERO) begin
               state_nxt_s = ST_ON;
            end else begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end
         end
         ST_ON: begin
            if (eff_mode_s != act_mode_r) begin
               state_nxt_s = ST_DRAIN;
               cnt_nxt_s   = DRAIN_LOAD;
            end else begin
               state_nxt_s = ST_ON;
            end
         end
         ST_DRAIN: begin
            // itxen is not looked at until the pipeline and tail are flushed.
            if (cnt_r == CNT_ZERO) begin
               if (eff_mode_s == MODE_DIS) begin
                  state_nxt_s = ST_OFF;
               end else begin
                  state_nxt_s    = ST_ARM;
                  cnt_nxt_s      = WAKE_LOAD;
                  act_mode_nxt_s = eff_mode_s;
               end
            end else begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_nxt_s    = ST_OFF;
            cnt_nxt_s      = CNT_ZERO;
            act_mode_nxt_s = MODE_DIS;
         end
      endcase
   end

   // Pipeline input word {rising, falling}: real data only while ON.
   always_comb begin
      pipe_in_s = 2'b00;
      if (state_r == ST_ON) begin
         case (act_mode_r)
            MODE_DDR: pipe_in_s = {idat0, idat1};
            MODE_SDR: pipe_in_s = {idat0, idat0};
            MODE_CLK: pipe_in_s = 2'b10;
            default:  pipe_in_s = 2'b00;
         endcase
      end else begin
         pipe_in_s = 2'b00;
      end
   end

   // Sequencer registers; the driver enable is registered from the next state
   // so it rises on the OFF->ARM edge and falls on the DRAIN->OFF edge.
   always_ff @(posedge iclkin_dist) begin
      if (irst) begin
         state_r    <= ST_OFF;
         cnt_r      <= CNT_ZERO;
         act_mode_r <= MODE_DIS;
         oe_r       <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         act_mode_r <= act_mode_nxt_s;
         oe_r       <= (state_nxt_s != ST_OFF);
      end
   end

   // Data pipeline: stage 0 takes the formatted word, the last stage drives odat.
   always_ff @(posedge iclkin_dist) begin
      if (irst) begin
         pipe_r <= '0;
      end else begin
         for (int i = PIPE_STG - 1; i > 0; i--) begin
            pipe_r[i] <= pipe_r[i-1];
         end
         pipe_r[0] <= pipe_in_s;
      end
   end

   assign odat0      = pipe_r[PIPE_STG-1][1];
   assign odat1      = pipe_r[PIPE_STG-1][0];
   assign otx_oe     = oe_r;
   assign owkpd_en   = ~oe_r;
   assign otx_ready  = (state_r == ST_ON) &&
                       ((act_mode_r == MODE_DDR) || (act_mode_r == MODE_SDR));
   assign oasync_dat = iasync_dat & (state_r == ST_ON) & (act_mode_r == MODE_ASYNC);

endmodule
